// File: rtl/csr_req_ctrl.sv
// csr_req_ctrl
// Initiator side of the CSR access interface. Takes one CSR instruction at a
// time from execute, runs it on the CSR file port as a READ phase (sample the
// old value under a preserve op) followed by a COMMIT phase (the actual write,
// or another preserve op when the instruction must not write). It then hands
// the old value to writeback.
//
// The CSR file treats ctrl=00/src=0 as "clear", so that pattern only ever
// appears together with IDLE_INDEX, which decodes to no CSR.

module csr_req_ctrl #(
    parameter int unsigned      DATA_W     = 64,
    parameter int unsigned      IDX_W      = 12,
    parameter logic [IDX_W-1:0] IDLE_INDEX = '0,
    parameter int unsigned      CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,

    // request from execute
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [1:0]        req_ctrl,
    input  logic              req_src,
    input  logic [DATA_W-1:0] req_rs1,
    input  logic [4:0]        req_zimm,
    input  logic              req_nowrite,
    input  logic [4:0]        req_rd,

    // CSR file port
    output logic [IDX_W-1:0]  csr_index,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] imm_csr,
    output logic [1:0]        csr_ctrl,
    output logic              csr_src,
    input  logic [DATA_W-1:0] csr_read,

    // response to writeback
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_wen,

    output logic [CNT_W-1:0]  op_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // ctrl=00 means "no modify"; with src=1 the CSR keeps its own next value,
    // with src=0 it is cleared.
    localparam logic [1:0] CTRL_NONE = 2'b00;

    state_e             r_state;

    // captured instruction
    logic [IDX_W-1:0]   r_index;
    logic [1:0]         r_ctrl;
    logic               r_src;
    logic [DATA_W-1:0]  r_rs1;
    logic [4:0]         r_zimm;
    logic               r_nowrite;

    // response and statistics
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [4:0]         r_rsp_rd;
    logic               r_rsp_wen;
    logic [CNT_W-1:0]   r_op_cnt;

    logic               w_accept;
    logic               w_rsp_fire;
    logic               w_commit_write;
    logic [DATA_W-1:0]  w_zimm_ext;

    logic [IDX_W-1:0]   w_csr_index;
    logic [DATA_W-1:0]  w_rs1_data;
    logic [DATA_W-1:0]  w_imm_csr;
    logic [1:0]         w_csr_ctrl;
    logic               w_csr_src;

    // NOTE: rst is folded in combinationally so the reset cycle itself already
    // shows req_ready=0 and an idle CSR port, even if the FSM sits in COMMIT.
    assign req_ready      = rst && (r_state == ST_IDLE);
    assign w_accept       = req_valid && req_ready;
    assign w_rsp_fire     = r_rsp_valid && rsp_ready;
    assign w_commit_write = (r_ctrl != CTRL_NONE) && !r_nowrite;
    assign w_zimm_ext     = {{(DATA_W-5){1'b0}}, r_zimm};

    // Control FSM and registered response / counter state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_rd    <= '0;
            r_rsp_wen   <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rsp_rd  <= req_rd;
                        r_rsp_wen <= (req_rd != 5'd0);
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_rsp_data <= csr_read;
                    r_state    <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        r_op_cnt    <= r_op_cnt + CNT_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Instruction capture on accept.
    // NOTE: these are pure payload registers qualified by the FSM, so they carry
    // no reset; their contents are never driven out while the FSM is IDLE.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_index   <= req_index;
            r_ctrl    <= req_ctrl;
            r_src     <= req_src;
            r_rs1     <= req_rs1;
            r_zimm    <= req_zimm;
            r_nowrite <= req_nowrite;
        end
    end

    // CSR port drive: idle pattern by default, preserve op in READ, real or
    // preserve op in COMMIT.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        w_csr_index = IDLE_INDEX;
        w_csr_ctrl  = CTRL_NONE;
        w_csr_src   = 1'b0;
        w_rs1_data  = '0;
        w_imm_csr   = '0;
        if (rst) begin
            unique case (r_state)
                ST_READ: begin
                    w_csr_index = r_index;
                    w_csr_src   = 1'b1;
                end
                ST_COMMIT: begin
                    w_csr_index = r_index;
                    if (w_commit_write) begin
                        w_csr_ctrl = r_ctrl;
                        w_csr_src  = r_src;
                        w_rs1_data = r_rs1;
                        w_imm_csr  = w_zimm_ext;
                    end else begin
                        w_csr_src  = 1'b1;
                    end
                end
                default: begin
                    w_csr_index = IDLE_INDEX;
                end
            endcase
        end
    end

    assign csr_index = w_csr_index;
    assign csr_ctrl  = w_csr_ctrl;
    assign csr_src   = w_csr_src;
    assign rs1_data  = w_rs1_data;
    assign imm_csr   = w_imm_csr;

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_wen   = r_rsp_wen;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_csr_req_ctrl.sv
// tb_csr_req_ctrl
// Directed bench for csr_req_ctrl. A small CSR file model (free-running
// mcycle, plain mscratch) answers the CSR port; expected responses are queued
// when a request is driven and popped when the DUT responds.

module tb_csr_req_ctrl;

    localparam int unsigned DATA_W       = 64;
    localparam int unsigned IDX_W        = 12;
    localparam int unsigned CNT_W        = 4;
    localparam logic [11:0] IDLE_INDEX   = 12'h000;
    localparam logic [11:0] IDX_MCYCLE   = 12'hB00;
    localparam logic [11:0] IDX_MSCRATCH = 12'h340;
    localparam logic [1:0]  C_RO = 2'b00, C_RW = 2'b01, C_RS = 2'b10, C_RC = 2'b11;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [IDX_W-1:0]  req_index = '0;
    logic [1:0]        req_ctrl = '0;
    logic              req_src = 1'b0;
    logic [DATA_W-1:0] req_rs1 = '0;
    logic [4:0]        req_zimm = '0;
    logic              req_nowrite = 1'b0;
    logic [4:0]        req_rd = '0;
    logic [IDX_W-1:0]  csr_index;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] imm_csr;
    logic [1:0]        csr_ctrl;
    logic              csr_src;
    logic [DATA_W-1:0] csr_read;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_wen;
    logic [CNT_W-1:0]  op_cnt;

    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    rsp_t             sb[$];

    csr_req_ctrl #(
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .IDLE_INDEX(IDLE_INDEX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_ctrl   (req_ctrl),
        .req_src    (req_src),
        .req_rs1    (req_rs1),
        .req_zimm   (req_zimm),
        .req_nowrite(req_nowrite),
        .req_rd     (req_rd),
        .csr_index  (csr_index),
        .rs1_data   (rs1_data),
        .imm_csr    (imm_csr),
        .csr_ctrl   (csr_ctrl),
        .csr_src    (csr_src),
        .csr_read   (csr_read),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_wen    (rsp_wen),
        .op_cnt     (op_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CSR file model ----------------
    logic [63:0] m_mcycle   = 64'd1000;
    logic [63:0] m_mscratch = 64'h0000_A5A0;
    int          n_hazard   = 0;
    logic [63:0] m_operand;

    assign m_operand = csr_src ? imm_csr : rs1_data;
    assign csr_read  = (csr_index == IDX_MCYCLE)   ? m_mcycle   :
                       (csr_index == IDX_MSCRATCH) ? m_mscratch : 64'd0;

    function automatic logic [63:0] csr_next(input logic [63:0] old, input logic [1:0] ctrl,
                                             input logic src, input logic [63:0] opnd);
        case (ctrl)
            C_RW:    return opnd;
            C_RS:    return old | opnd;
            C_RC:    return old & ~opnd;
            default: return src ? old : 64'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (csr_index == IDX_MCYCLE && !(csr_ctrl == C_RO && csr_src))
            m_mcycle <= csr_next(m_mcycle, csr_ctrl, csr_src, m_operand);
        else
            m_mcycle <= m_mcycle + 64'd1;
        if (csr_index == IDX_MSCRATCH)
            m_mscratch <= csr_next(m_mscratch, csr_ctrl, csr_src, m_operand);
        if (csr_ctrl == C_RO && !csr_src && csr_index != IDLE_INDEX)
            n_hazard <= n_hazard + 1;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request in the current (IDLE) cycle and return just after the
    // accept edge, i.e. in the READ cycle.
    task automatic send(input logic [11:0] idx, input logic [1:0] ctrl, input logic src,
                        input logic [63:0] rs1, input logic [4:0] zimm,
                        input logic nowrite, input logic [4:0] rd);
        rsp_t e;
        check("req_ready_idle", req_ready, 1'b1);
        req_valid   = 1'b1;
        req_index   = idx;
        req_ctrl    = ctrl;
        req_src     = src;
        req_rs1     = rs1;
        req_zimm    = zimm;
        req_nowrite = nowrite;
        req_rd      = rd;
        // value the CSR will show in the READ cycle (next cycle)
        if (idx == IDX_MCYCLE)        e.data = m_mcycle + 64'd1;
        else if (idx == IDX_MSCRATCH) e.data = m_mscratch;
        else                          e.data = 64'd0;
        e.rd  = rd;
        e.wen = (rd != 5'd0);
        sb.push_back(e);
        step();
        req_valid = 1'b0;
    endtask

    // Wait for the response, optionally stall it, then complete the handshake.
    task automatic collect(input int hold, input logic stray);
        rsp_t e;
        int   n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("rsp_valid_seen", rsp_valid, 1'b1);
        check("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            req_valid = stray;
            req_rd    = 5'd31;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data", rsp_data, e.data);
            check("hold_rd", rsp_rd, e.rd);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_csr_index", csr_index, IDLE_INDEX);
            check("hold_csr_ctrl", csr_ctrl, C_RO);
            check("hold_op_cnt", op_cnt, exp_cnt);
            step();
        end
        req_valid = 1'b0;
        check("rsp_data", rsp_data, e.data);
        check("rsp_rd", rsp_rd, e.rd);
        check("rsp_wen", rsp_wen, e.wen);
        rsp_ready = 1'b1;
        exp_cnt   = exp_cnt + 1'b1;
        step();
        rsp_ready = 1'b0;
        check("op_cnt", op_cnt, exp_cnt);
        check("rsp_valid_drop", rsp_valid, 1'b0);
        check("req_ready_back", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] v;
        int          c0;

        // reset state
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_csr_index", csr_index, IDLE_INDEX);
        check("rst_csr_ctrl", csr_ctrl, C_RO);
        check("rst_csr_src", csr_src, 1'b0);
        step();
        step();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_wen", rsp_wen, 1'b0);
        check("rst_op_cnt", op_cnt, 4'd0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", req_ready, 1'b1);
        step();

        // 1: csrrw mcycle, rs1=0x100, rd=5
        send(IDX_MCYCLE, C_RW, 1'b0, 64'h100, 5'd0, 1'b0, 5'd5);
        check("t1_read_index", csr_index, IDX_MCYCLE);
        check("t1_read_ctrl", csr_ctrl, C_RO);
        check("t1_read_src", csr_src, 1'b1);
        check("t1_read_rsp_valid", rsp_valid, 1'b0);
        check("t1_read_req_ready", req_ready, 1'b0);
        step();
        check("t1_commit_index", csr_index, IDX_MCYCLE);
        check("t1_commit_ctrl", csr_ctrl, C_RW);
        check("t1_commit_src", csr_src, 1'b0);
        check("t1_commit_rs1", rs1_data, 64'h100);
        check("t1_commit_rsp_valid", rsp_valid, 1'b0);
        step();
        check("t1_latency_valid", rsp_valid, 1'b1);
        check("t1_mcycle_written", m_mcycle, 64'h100);
        check("t1_resp_index", csr_index, IDLE_INDEX);
        collect(0, 1'b0);
        check("t1_mcycle_next", m_mcycle, 64'h101);

        // 2: csrrs mscratch zimm=3, then csrrc rs1=0xF
        send(IDX_MSCRATCH, C_RS, 1'b1, 64'hFFFF, 5'h3, 1'b0, 5'd6);
        step();
        check("t2_commit_ctrl", csr_ctrl, C_RS);
        check("t2_commit_src", csr_src, 1'b1);
        check("t2_commit_imm", imm_csr, 64'h3);
        collect(0, 1'b0);
        check("t2_mscratch_set", m_mscratch, 64'hA5A3);
        send(IDX_MSCRATCH, C_RC, 1'b0, 64'hF, 5'd0, 1'b0, 5'd7);
        collect(0, 1'b0);
        check("t2_mscratch_clr", m_mscratch, 64'hA5A0);

        // 3: csrrs mcycle with nowrite=1, rd=0
        send(IDX_MCYCLE, C_RS, 1'b0, 64'hFFFF_0000, 5'd0, 1'b1, 5'd0);
        step();
        check("t3_commit_ctrl", csr_ctrl, C_RO);
        check("t3_commit_src", csr_src, 1'b1);
        v = m_mcycle;
        step();
        check("t3_mcycle_counts", m_mcycle, v + 64'd1);
        collect(0, 1'b0);

        // 4: read-only mscratch, writeback stalls 5 cycles, stray req_valid
        send(IDX_MSCRATCH, C_RO, 1'b0, 64'hDEAD, 5'd9, 1'b0, 5'd12);
        collect(5, 1'b1);
        check("t4_mscratch_kept", m_mscratch, 64'hA5A0);
        step();
        check("t4_no_stray_accept", rsp_valid, 1'b0);
        check("t4_still_idle", req_ready, 1'b1);

        // 5: reset asserted during COMMIT of a csrrw mcycle
        send(IDX_MCYCLE, C_RW, 1'b0, 64'h55, 5'd0, 1'b0, 5'd7);
        step();
        rst = 1'b0;
        #1;
        check("t5_port_idle_index", csr_index, IDLE_INDEX);
        check("t5_port_idle_ctrl", csr_ctrl, C_RO);
        check("t5_req_ready_low", req_ready, 1'b0);
        v = m_mcycle;
        step();
        check("t5_no_write", m_mcycle, v + 64'd1);
        check("t5_rsp_valid", rsp_valid, 1'b0);
        check("t5_op_cnt", op_cnt, 4'd0);
        check("t5_rsp_data", rsp_data, 64'd0);
        check("t5_rsp_rd", rsp_rd, 5'd0);
        check("t5_req_ready_rst", req_ready, 1'b0);
        sb.delete();
        exp_cnt = '0;
        rst = 1'b1;
        #1;
        check("t5_req_ready_after", req_ready, 1'b1);
        step();
        check("t5_mcycle_free", m_mcycle, v + 64'd2);

        // 6: 16 back-to-back ops, 4-bit counter wraps 15 -> 0
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            send(IDX_MSCRATCH, C_RO, 1'b0, 64'd0, 5'd0, 1'b0, 5'(i + 1));
            collect(0, 1'b0);
        end
        check("t6_op_cnt_wrap", op_cnt, 4'd0);
        check("t6_throughput", cyc - c0, 64);

        check("no_clear_hazard", n_hazard, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
